// File: rtl/booth_seq_mult.sv
// Iterative radix-2 Booth multiplier: one add/sub/shift step per clock over a
// WIDTH+1 bit datapath, with runtime signed/unsigned mode and START/BUSY/DONE.
module booth_seq_mult #(
    parameter int WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 START,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   P
);

    localparam int unsigned N  = WIDTH + 1;
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state;
    logic [N-1:0]    acc;
    logic [N-1:0]    q;
    logic            q_m1;
    logic [N-1:0]    m;
    logic [CW-1:0]   cnt;

    logic [N-1:0]    a_ext;
    logic [N-1:0]    b_ext;
    logic [N-1:0]    sum;
    logic [2*N:0]    shifted;

    // The guard bit lets one signed datapath handle unsigned operands too.
    assign a_ext = {SIGNED_MODE & A[WIDTH-1], A};
    assign b_ext = {SIGNED_MODE & B[WIDTH-1], B};

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        shifted = {sum[N-1], sum, q};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            acc   <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            m     <= '0;
            cnt   <= '0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
            P     <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        acc   <= '0;
                        q     <= a_ext;
                        q_m1  <= 1'b0;
                        m     <= b_ext;
                        cnt   <= CW'(N);
                        BUSY  <= 1'b1;
                        state <= S_RUN;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc  <= shifted[2*N:N+1];
                    q    <= shifted[N:1];
                    q_m1 <= shifted[0];
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        // Product taken from the post-shift value of {acc,q}.
                        P     <= shifted[2*WIDTH:1];
                        BUSY  <= 1'b0;
                        DONE  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: directed table for WIDTH=16, multi-cycle
// handshake/reset sequences, and random WIDTH=8 vectors against an arithmetic model.
module tb_booth_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    logic        start16, sm16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] p16;

    logic        start8, sm8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    booth_seq_mult #(.WIDTH(16)) dut16 (
        .CLK(clk), .RST_N(rst_n), .START(start16), .SIGNED_MODE(sm16),
        .A(a16), .B(b16), .BUSY(busy16), .DONE(done16), .P(p16)
    );

    booth_seq_mult #(.WIDTH(8)) dut8 (
        .CLK(clk), .RST_N(rst_n), .START(start8), .SIGNED_MODE(sm8),
        .A(a8), .B(b8), .BUSY(busy8), .DONE(done8), .P(p8)
    );

    typedef struct {
        logic        sm;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] ref8(input logic sm, input logic [7:0] a, input logic [7:0] b);
        longint x, y;
        x = sm ? longint'($signed(a)) : longint'(a);
        y = sm ? longint'($signed(b)) : longint'(b);
        return 16'(x * y);
    endfunction

    // Call just after the edge that sampled START; returns at the DONE cycle.
    task automatic wait16(input bit scramble, output int lat, output int busy_n, output bit p_moved);
        logic [31:0] p0;
        p0 = p16;
        lat = 0; busy_n = 0; p_moved = 0;
        while (lat < 60) begin
            @(negedge clk);
            if (done16) return;
            if (busy16) busy_n++;
            if (p16 !== p0) p_moved = 1;
            if (scramble) begin
                a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run16(input logic sm, input logic [15:0] a, input logic [15:0] b,
                         output logic [31:0] p, output int lat, output int busy_n);
        bit moved;
        @(negedge clk);
        sm16 = sm; a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        wait16(1'b1, lat, busy_n, moved);
        p = p16;
    endtask

    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int lat);
        @(negedge clk);
        sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            if (done8) break;
            a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
            @(posedge clk);
            lat++;
        end
        p = p8;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        tbl[$];
        logic [31:0] p;
        logic [15:0] pp8;
        int          lat, busy_n, t1, t2, seen_done;
        bit          moved;

        tbl.push_back('{1'b1, 16'h0003, 16'hFFFB, 32'hFFFF_FFF1});
        tbl.push_back('{1'b1, 16'h8000, 16'h8000, 32'h4000_0000});
        tbl.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001});
        tbl.push_back('{1'b1, 16'h7FFF, 16'h8000, 32'hC000_8000});
        tbl.push_back('{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001});
        tbl.push_back('{1'b0, 16'h8000, 16'h0002, 32'h0001_0000});
        tbl.push_back('{1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0001});

        start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
        start8 = 0;  sm8 = 0;  a8 = 0;  b8 = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 64'(busy16), 64'd0);
        chk("reset_done", 64'(done16), 64'd0);
        chk("reset_p", 64'(p16), 64'd0);
        chk("reset_p8", 64'(p8), 64'd0);
        rst_n = 1'b1;

        // Directed vectors: product, latency, busy duration, single DONE pulse.
        foreach (tbl[i]) begin
            run16(tbl[i].sm, tbl[i].a, tbl[i].b, p, lat, busy_n);
            chk($sformatf("vec%0d_p", i), 64'(p), 64'(tbl[i].p));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd17);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd17);
            chk($sformatf("vec%0d_busy_at_done", i), 64'(busy16), 64'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_single", i), 64'(done16), 64'd0);
        end

        // Back-to-back with START held high and operands scrambled during RUN.
        @(negedge clk);
        sm16 = 1'b1; a16 = 16'd5; b16 = 16'd7; start16 = 1'b1;
        @(posedge clk);
        #1;
        wait16(1'b1, lat, busy_n, moved);
        t1 = cyc;
        chk("b2b_first_p", 64'(p16), 64'h23);
        chk("b2b_first_latency", 64'(lat), 64'd17);
        sm16 = 1'b1; a16 = 16'hFFFE; b16 = 16'd9;
        @(posedge clk);
        #1;
        wait16(1'b1, lat, busy_n, moved);
        t2 = cyc;
        start16 = 1'b0;
        chk("b2b_p_stable_during_run", 64'(moved), 64'd0);
        chk("b2b_second_p", 64'(p16), 64'hFFFF_FFEE);
        chk("b2b_done_spacing", 64'(t2 - t1), 64'd18);
        @(negedge clk);
        chk("b2b_done_single", 64'(done16), 64'd0);

        // Asynchronous reset in the 8th RUN cycle.
        @(negedge clk);
        sm16 = 1'b0; a16 = 16'h1234; b16 = 16'h0005; start16 = 1'b1;
        @(posedge clk);
        #1 start16 = 1'b0;
        repeat (7) @(posedge clk);
        #3;
        chk("rst_busy_before", 64'(busy16), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_async", 64'(busy16), 64'd0);
        chk("rst_done_async", 64'(done16), 64'd0);
        chk("rst_p_async", 64'(p16), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done16) seen_done++;
        end
        chk("rst_no_done_after", 64'(seen_done), 64'd0);
        run16(1'b1, 16'h0002, 16'h0003, p, lat, busy_n);
        chk("rst_then_run_p", 64'(p), 64'h6);
        chk("rst_then_run_latency", 64'(lat), 64'd17);

        // Random WIDTH=8 vectors against the arithmetic model.
        for (int i = 0; i < 1000; i++) begin
            logic       sm;
            logic [7:0] a, b;
            sm = 1'($urandom);
            a  = 8'($urandom);
            b  = 8'($urandom);
            if (i == 0) begin sm = 1'b1; a = 8'h80; b = 8'h80; end
            if (i == 1) begin sm = 1'b0; a = 8'hFF; b = 8'hFF; end
            run8(sm, a, b, pp8, lat);
            chk($sformatf("w8_p[%0d] sm=%0d a=%0h b=%0h", i, sm, a, b), 64'(pp8), 64'(ref8(sm, a, b)));
            chk($sformatf("w8_latency[%0d]", i), 64'(lat), 64'd9);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
